// File: rtl/button_pkg.sv
// button_pkg: shared defaults, repeat-state encoding and counter-width helpers for the button front end.
package button_pkg;
  localparam int DEF_CHANNELS = 4;
  localparam bit DEF_ACTIVE_LOW = 1'b1;
  localparam int DEF_DEBOUNCE_CYCLES = 1_250_000;
  localparam int DEF_REPEAT_DELAY_CYCLES = 25_000_000;
  localparam int DEF_REPEAT_RATE_CYCLES = 5_000_000;
  typedef enum logic [1:0] {IDLE, DELAY, RATE} rpt_state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
  localparam int DEF_DB_W = cnt_w(DEF_DEBOUNCE_CYCLES);
  localparam int DEF_RPT_W = cnt_w(max2(DEF_REPEAT_DELAY_CYCLES, DEF_REPEAT_RATE_CYCLES));
endpackage

// File: rtl/button_channel.sv
// button_channel: synchroniser, debounce, edge strobes and auto-repeat FSM for one button.
module button_channel
  import button_pkg::*;
#(
  parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES = DEF_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);
  localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam int RPT_W = cnt_w(max2(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DLY_MAX = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RATE_MAX = RPT_W'(REPEAT_RATE_CYCLES - 1);
  logic [1:0] sync_q;
  logic raw, db_done, rise, fall;
  logic level_q, level_d, press_q, release_q, rpt_q, rpt_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  rpt_state_t state_q, state_d;
  assign raw = sync_q[1] ^ ACTIVE_LOW;
  always_comb begin
    db_done = (raw != level_q) && (db_cnt_q == DB_MAX);
    db_cnt_d = (raw == level_q || db_done) ? '0 : db_cnt_q + 1'b1;
    level_d = db_done ? raw : level_q;
    rise = level_d & ~level_q;
    fall = ~level_d & level_q;
  end
  // Abort uses the next level so a release edge suppresses any repeat due in that cycle.
  always_comb begin
    state_d = state_q;
    rpt_cnt_d = rpt_cnt_q + 1'b1;
    rpt_d = 1'b0;
    if (!level_d || !repeat_en) begin
      state_d = IDLE;
      rpt_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          rpt_cnt_d = '0;
          state_d = rise ? DELAY : IDLE;
        end
        DELAY: if (rpt_cnt_q == DLY_MAX) begin
          rpt_d = 1'b1;
          rpt_cnt_d = '0;
          state_d = RATE;
        end
        RATE: if (rpt_cnt_q == RATE_MAX) begin
          rpt_d = 1'b1;
          rpt_cnt_d = '0;
        end
        default: begin
          state_d = IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q <= {2{ACTIVE_LOW}};
      level_q <= 1'b0;
      db_cnt_q <= '0;
      press_q <= 1'b0;
      release_q <= 1'b0;
      rpt_q <= 1'b0;
      rpt_cnt_q <= '0;
      state_q <= IDLE;
    end else begin
      sync_q <= {sync_q[0], btn_in};
      level_q <= level_d;
      db_cnt_q <= db_cnt_d;
      press_q <= rise;
      release_q <= fall;
      rpt_q <= rpt_d;
      rpt_cnt_q <= rpt_cnt_d;
      state_q <= state_d;
    end
  assign level = level_q;
  assign press_pulse = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse = rpt_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button front end, one independent button_channel per key.
module button_conditioner
  import button_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES = DEF_REPEAT_RATE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW(ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES(REPEAT_RATE_CYCLES)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .btn_in(btn_in[c]),
      .repeat_en(repeat_en[c]),
      .level(level[c]),
      .press_pulse(press_pulse[c]),
      .release_pulse(release_pulse[c]),
      .repeat_pulse(repeat_pulse[c])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus checked every cycle against an event-level reference model.
module tb_button_conditioner;
  localparam int CH = 2;
  localparam bit AL = 1'b1;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RR = 5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CH-1:0] btn_in = '1;
  logic [CH-1:0] repeat_en = '0;
  logic [CH-1:0] level, press_pulse, release_pulse, repeat_pulse;
  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  bit d1[CH], d2[CH], lvl[CH], armed[CH];
  int run[CH], press_t[CH];
  logic [CH-1:0] e_lvl, e_prs, e_rel, e_rpt;
  button_conditioner #(
    .CHANNELS(CH),
    .ACTIVE_LOW(AL),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES(RR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .repeat_en(repeat_en),
    .level(level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, t);
    end
  endtask
  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, t);
    end
  endtask
  task automatic check_all();
    chk("level", level, e_lvl);
    chk("press_pulse", press_pulse, e_prs);
    chk("release_pulse", release_pulse, e_rel);
    chk("repeat_pulse", repeat_pulse, e_rpt);
  endtask
  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      d1[c] = 1'b0;
      d2[c] = 1'b0;
      lvl[c] = 1'b0;
      armed[c] = 1'b0;
      run[c] = 0;
    end
    e_lvl = '0;
    e_prs = '0;
    e_rel = '0;
    e_rpt = '0;
  endtask
  // One clock edge: the key reaches the debouncer two edges after sampling, the level flips after DB
  // consecutive disagreeing edges, and repeats fall at RD, RD+RR, ... edges after an armed press.
  task automatic step();
    bit rawp, prev;
    int e;
    @(posedge clk);
    t++;
    if (reset) model_reset();
    else for (int c = 0; c < CH; c++) begin
      rawp = d2[c];
      prev = lvl[c];
      d2[c] = d1[c];
      d1[c] = btn_in[c] ^ AL;
      e_prs[c] = 1'b0;
      e_rel[c] = 1'b0;
      e_rpt[c] = 1'b0;
      if (rawp != lvl[c]) begin
        run[c]++;
        if (run[c] == DB) begin
          lvl[c] = rawp;
          run[c] = 0;
        end
      end else run[c] = 0;
      if (lvl[c] && !prev) begin
        e_prs[c] = 1'b1;
        armed[c] = repeat_en[c];
        press_t[c] = t;
      end else if (!lvl[c] && prev) begin
        e_rel[c] = 1'b1;
        armed[c] = 1'b0;
      end else if (lvl[c] && armed[c]) begin
        if (!repeat_en[c]) armed[c] = 1'b0;
        else begin
          e = t - press_t[c];
          e_rpt[c] = (e == RD) || (e > RD && (e - RD) % RR == 0);
        end
      end
      e_lvl[c] = lvl[c];
    end
    #1;
    check_all();
  endtask
  task automatic run_n(input int n);
    repeat (n) step();
  endtask
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    run_n(2);
    reset = 1'b0;
  endtask
  initial begin
    int tp;
    bit got;
    model_reset();
    #1 check_all();
    run_n(3);
    reset = 1'b0;
    run_n(3);
    // clean press and release on ch0
    btn_in[0] = 1'b0;
    run_n(40);
    btn_in[0] = 1'b1;
    run_n(20);
    // bounce then settle pressed
    for (int i = 0; i < 10; i++) begin
      btn_in[0] = ~btn_in[0];
      run_n(3);
    end
    btn_in[0] = 1'b0;
    run_n(30);
    btn_in[0] = 1'b1;
    run_n(20);
    // auto-repeat on ch1, release timed onto a due repeat
    repeat_en[1] = 1'b1;
    btn_in[1] = 1'b0;
    tp = -1;
    got = 1'b0;
    for (int i = 0; i < 200 && !(tp >= 0 && t == tp + 30); i++) begin
      step();
      if (press_pulse[1]) tp = t;
      if (repeat_pulse[1] && tp >= 0 && !got) begin
        got = 1'b1;
        chk_i("first_repeat_gap", t - tp, RD);
      end
    end
    chk_i("repeat_seen", int'(got), 1);
    btn_in[1] = 1'b1;
    run_n(20);
    // simultaneous press, repeat only on ch1
    repeat_en = 2'b10;
    btn_in = 2'b00;
    run_n(45);
    btn_in = 2'b11;
    run_n(20);
    // reset mid-debounce with the key held
    btn_in[0] = 1'b0;
    run_n(7);
    pulse_reset();
    run_n(15);
    // reset mid-RATE
    repeat_en = 2'b11;
    btn_in[1] = 1'b0;
    run_n(36);
    pulse_reset();
    run_n(12);
    btn_in = 2'b11;
    run_n(15);
    // repeat enable dropped in RATE, re-raised while held
    btn_in[1] = 1'b0;
    run_n(36);
    repeat_en[1] = 1'b0;
    run_n(10);
    repeat_en[1] = 1'b1;
    run_n(40);
    btn_in[1] = 1'b1;
    run_n(15);
    btn_in[1] = 1'b0;
    run_n(35);
    btn_in[1] = 1'b1;
    run_n(15);
    // random segments
    for (int k = 0; k < 40; k++) begin
      btn_in = CH'($urandom);
      if ($urandom_range(0, 7) == 0) repeat_en = CH'($urandom);
      run_n($urandom_range(1, 40));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
